// File: rtl/de4_sopc_timing_adapter_rl1_to_rl0.sv
// Avalon-ST timing adapter: ready-latency-1 sink to ready-latency-0 source.
// A show-ahead FIFO with a look-ahead registered in_ready absorbs the beat that may follow in_ready falling.
module de4_sopc_timing_adapter_rl1_to_rl0 #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ERROR_W = 6,
    parameter int unsigned EMPTY_W = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [ERROR_W-1:0] in_error,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [ERROR_W-1:0] out_error,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty
);
    localparam int unsigned PAYLOAD_W = DATA_W + ERROR_W + EMPTY_W + 2;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned SUM_W     = CNT_W + 1;

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 in_ready_dly_q;
    logic                 wr_en;
    logic                 rd_en;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    assign in_payload = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};
    assign wr_en      = in_valid && in_ready_dly_q;
    assign out_valid  = (count_q != '0);
    assign rd_en      = out_valid && out_ready;
    assign in_ready   = in_ready_q;

    // Next-state: pointers, occupancy, and in_ready holding a slot for the beat it may still admit.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (SUM_W'(count_d) + SUM_W'(in_ready_q)) < SUM_W'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            in_ready_q     <= 1'b0;
            in_ready_dly_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            in_ready_q     <= in_ready_d;
            in_ready_dly_q <= in_ready_q;
        end
    end

    // Payload storage is not reset; stale contents are hidden by out_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_payload;
        end
    end

    assign out_payload = mem_q[rd_ptr_q];
    assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = out_payload;

endmodule

// File: tb/tb_de4_sopc_timing_adapter_rl1_to_rl0.sv
// Self-checking bench for the RL1-to-RL0 timing adapter: directed vectors plus a beat scoreboard.
module tb_de4_sopc_timing_adapter_rl1_to_rl0;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ERROR_W = 6;
    localparam int unsigned EMPTY_W = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PW      = DATA_W + ERROR_W + EMPTY_W + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_ready;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [ERROR_W-1:0] in_error;
    logic               in_startofpacket;
    logic               in_endofpacket;
    logic [EMPTY_W-1:0] in_empty;
    logic               out_ready;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [ERROR_W-1:0] out_error;
    logic               out_startofpacket;
    logic               out_endofpacket;
    logic [EMPTY_W-1:0] out_empty;

    always #5 clk = ~clk;

    de4_sopc_timing_adapter_rl1_to_rl0 #(
        .DATA_W (DATA_W),
        .ERROR_W(ERROR_W),
        .EMPTY_W(EMPTY_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_error         (in_error),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_empty         (in_empty),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_error        (out_error),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .out_empty        (out_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [PW-1:0] beat(input logic [DATA_W-1:0] d, input logic [ERROR_W-1:0] e,
                                           input logic s, input logic eo, input logic [EMPTY_W-1:0] em);
        return {d, e, s, eo, em};
    endfunction

    function automatic logic [DATA_W-1:0] pdata(input logic [PW-1:0] p);
        return p[PW-1 -: DATA_W];
    endfunction

    function automatic logic [ERROR_W-1:0] perr(input logic [PW-1:0] p);
        return p[EMPTY_W+2 +: ERROR_W];
    endfunction

    logic [PW-1:0] in_pl, out_pl;
    assign in_pl  = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};
    assign out_pl = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};

    // Scoreboard: a beat is accepted when in_valid follows a cycle with in_ready high.
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] pop_log[$];
    int            acc_cyc[$];
    int            pop_cyc[$];
    int            occ      = 0;
    int            max_occ  = 0;
    int            late_acc = 0;
    int            cyc      = 0;
    logic          ir_last  = 1'b0;

    always @(negedge clk) begin
        logic [PW-1:0] e;
        cyc++;
        if (reset) begin
            exp_q.delete();
            occ     = 0;
            ir_last = 1'b0;
        end else begin
            check("out_valid", out_valid, occ != 0);
            if (out_valid && out_ready) begin
                pop_log.push_back(out_pl);
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", out_pl, e);
                    occ--;
                end
            end
            if (in_valid && ir_last) begin
                exp_q.push_back(in_pl);
                acc_cyc.push_back(cyc);
                occ++;
                if (!in_ready) late_acc++;
            end
            if (occ > max_occ) max_occ = occ;
            ir_last = in_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] pl);
        in_valid = v;
        {in_data, in_error, in_startofpacket, in_endofpacket, in_empty} = pl;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        acc_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0);
        repeat (3) tick();
        reset = 1'b0;
        check({tag, "_ir_after"}, in_ready, 0);
        check({tag, "_ov_after"}, out_valid, 0);
        tick();
        check({tag, "_ir_2nd"}, in_ready, 1);
        check({tag, "_ov_2nd"}, out_valid, 0);
    endtask

    task automatic send_beat(input logic [PW-1:0] pl);
        int guard = 0;
        while (!ir_last && guard < 200) begin
            drive(1'b0, '0);
            tick();
            guard++;
        end
        if (!ir_last) check("send_timeout", 0, 1);
        drive(1'b1, pl);
        tick();
    endtask

    task automatic drain();
        drive(1'b0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && occ != 0; i++) tick();
        check("drain_ov", out_valid, 0);
        check("drain_q", exp_q.size(), 0);
        repeat (2) tick();
    endtask

    logic [DATA_W-1:0] late_data [6] = '{32'h100, 32'h101, 32'h102, 32'hA5A5A5A5, 32'hDEAD0004, 32'hDEAD0005};
    logic [5:0]        late_ir       = 6'b000111;

    initial begin
        int sent;
        int seq;
        logic v;

        drive(1'b0, '0);
        out_ready = 1'b0;
        do_reset("rst");

        // Streaming: 64-beat packet, out_ready held high.
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++)
            send_beat(beat(DATA_W'(i), '0, i == 0, i == 63, 2'd2));
        drain();
        check("stream_cnt", pop_log.size(), 64);
        check("stream_first", pop_log[0], {32'h0, 6'h0, 1'b1, 1'b0, 2'd2});
        check("stream_last", pop_log[63], {32'd63, 6'h0, 1'b0, 1'b1, 2'd2});
        check("stream_latency", pop_cyc[0] - acc_cyc[0], 1);
        check("stream_in_gaps", acc_cyc[63] - acc_cyc[0], 63);
        check("stream_out_gaps", pop_cyc[63] - pop_cyc[0], 63);

        // Backpressure: out_ready low for 10 cycles during a continuous stream.
        clear_logs();
        late_acc = 0;
        max_occ  = 0;
        seq      = 0;
        for (int k = 0; k < 40; k++) begin
            out_ready = !(k >= 8 && k < 18);
            if (k == 17) begin
                check("bp_full_occ", occ, 4);
                check("bp_full_ir", in_ready, 0);
                check("bp_full_ov", out_valid, 1);
            end
            if (ir_last) begin
                drive(1'b1, beat(DATA_W'(32'h1000 + seq), '0, 1'b0, 1'b0, '0));
                seq++;
            end else begin
                drive(1'b0, '0);
            end
            tick();
        end
        drain();
        check("bp_late_beats", late_acc, 1);
        check("bp_max_occ", max_occ, 4);
        check("bp_count", pop_log.size(), seq);

        // Late beat: in_valid held every cycle with out_ready low.
        clear_logs();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("late_ir", in_ready, late_ir[k]);
            drive(1'b1, beat(late_data[k], '0, 1'b0, 1'b0, '0));
            tick();
        end
        drain();
        check("late_cnt", pop_log.size(), 4);
        for (int k = 0; k < 4 && k < pop_log.size(); k++)
            check("late_data", pdata(pop_log[k]), late_data[k]);

        // Simultaneous read/write at two stored beats, error field carried.
        clear_logs();
        out_ready = 1'b0;
        send_beat(beat(32'h200, 6'h2A, 1'b1, 1'b0, 2'd0));
        send_beat(beat(32'h201, 6'h2A, 1'b0, 1'b0, 2'd1));
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            check("rw_occ", occ, 2);
            check("rw_ir", in_ready, 1);
            drive(1'b1, beat(DATA_W'(32'h202 + j), 6'h2A, 1'b0, j == 19, EMPTY_W'(j)));
            tick();
        end
        drain();
        check("rw_cnt", pop_log.size(), 22);
        for (int i = 0; i < 22 && i < pop_log.size(); i++) begin
            check("rw_data", pdata(pop_log[i]), 32'h200 + i);
            check("rw_err", perr(pop_log[i]), 6'h2A);
        end

        // Reset mid-stream with three beats stored.
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(beat(DATA_W'(32'h300 + i), '0, i == 0, 1'b0, '0));
        drive(1'b0, '0);
        check("mid_pre_ov", out_valid, 1);
        check("mid_pre_occ", occ, 3);
        do_reset("mid");
        clear_logs();
        out_ready = 1'b1;
        send_beat(beat(32'h777, 6'h01, 1'b1, 1'b1, 2'd3));
        drain();
        check("mid_cnt", pop_log.size(), 1);
        if (pop_log.size() > 0) check("mid_data", pdata(pop_log[0]), 32'h777);

        // Random valid (50%) and out_ready (30%); ignored beats carry garbage.
        clear_logs();
        max_occ = 0;
        sent    = 0;
        for (int c = 0; c < 80000 && sent < 10000; c++) begin
            out_ready = ($urandom_range(0, 9) < 3);
            v = 1'($urandom_range(0, 1));
            if (v && ir_last) sent++;
            drive(v, beat($urandom(), ERROR_W'($urandom()), 1'($urandom()), 1'($urandom()), EMPTY_W'($urandom())));
            tick();
        end
        check("rand_sent", sent, 10000);
        drain();
        check("rand_pops", pop_log.size(), 10000);
        check("rand_max_occ", max_occ <= DEPTH, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
